ascii_key_mux: RTL and testbench
================================

Name: ascii_key_mux

Overview:
- Merges two ASCII sources into the single Apple-1 keyboard register pair (KBD data / KBDCR status) read by the CPU through the PIA decode.
  - Typed keys come from the PS/2-to-ASCII translator.
  - Streamed file bytes come from the ascii file-load stage.
- Typed keys are buffered in a small FIFO and always take priority over streamed bytes.
- Streamed bytes are paced so the Apple-1 monitor can keep up, and an ESC keystroke aborts a running stream.

Parameters:
- FIFO_DEPTH, 8, typed-key FIFO entries; power of two, 2..16.
- PACE_CYCLES, 16'd2500, minimum clk25 cycles after a CPU data read before the next streamed byte is accepted; 0 disables pacing.
- FORCE_UPPER, 1, when 1, ASCII 'a'..'z' (7'h61..7'h7a) is mapped to 'A'..'Z' on both sources.

Ports:
- clk25  input  1  system clock, 25 MHz.
- rst  input  1  reset, synchronous, active-high.
- kbd_ascii  input  7  typed character.
- kbd_valid  input  1  one-cycle strobe; kbd_ascii is valid this cycle.
- strm_ascii  input  7  streamed character.
- strm_valid  input  1  streamed character present; held until accepted.
- strm_ready  output  1  byte accepted when strm_valid & strm_ready.
- strm_active  input  1  stream source has data pending (file loaded, not exhausted).
- strm_abort  output  1  one-cycle pulse requesting the stream source to stop.
- cs  input  1  chip select from PIA decode, active high.
- address  input  1  0 = KBD data, 1 = KBDCR status.
- dout  output  8  registered read data.
- key_ready  output  1  holding register full (mirrors KBDCR bit 7).
- fifo_ovf  output  1  sticky flag: a typed key was dropped.

Behaviour:

Reset (synchronous; wins over all other activity in the same cycle):
- dout = 8'h00, key_ready = 0, strm_ready = 0, strm_abort = 0, fifo_ovf = 0.
- FIFO emptied; pace counter = 0; holding register = 7'h00.

Character mapping (combinational, applied before storage):
- 7'h0a becomes 7'h0d.
- If FORCE_UPPER, 7'h61..7'h7a have 7'h20 subtracted.
- All other codes pass unchanged. Both sources are mapped.

Typed-key FIFO:
- Push on kbd_valid when not full.
- Push when full: the key is dropped and fifo_ovf is set (cleared only by rst).
- Simultaneous push and pop are allowed at any fill level, including full. When full, the pop frees the slot and the push succeeds with no overflow.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

ESC handling:
- A kbd_valid with code 7'h1b while strm_active = 1 pulses strm_abort for one cycle in the next cycle.
- That ESC is also pushed into the FIFO.

Holding register load (evaluated each cycle when key_ready = 0 at cycle start):
1. FIFO not empty: pop the head into the holding register; key_ready = 1 next cycle.
2. Otherwise, if strm_active & strm_valid & pace counter = 0 & no abort pending: accept the byte (strm_ready = 1 this cycle), load it, key_ready = 1 next cycle.
- strm_ready is combinational: ~key_ready & FIFO empty & pace counter = 0 & strm_active & ~strm_abort.
- Latency from kbd_valid (FIFO empty, key_ready = 0) to key_ready = 1 is 2 cycles: push, then pop/load.

CPU interface (registered, evaluated each cycle cs = 1):
- address = 0: dout <= {1'b1, hold}; key_ready <= 0; pace counter <= PACE_CYCLES.
- address = 1: dout <= {key_ready, 7'b0}.
- cs held for several cycles repeats the action; repeat clears are harmless.
- No new load can occur in the same cycle as a clear, because a load requires key_ready = 0 at cycle start.
- cs = 0: dout holds its value.

Pace counter:
- Decrements by 1 each cycle while nonzero.
- Gates only the stream source; typed keys are never paced.
- A reload by a data read overrides the decrement.

strm_active falling mid-pace:
- No stream acceptance occurs.
- The counter still runs down normally.

Test Plan:
- Reset with all inputs idle → dout = 8'h00, key_ready = 0, strm_ready = 0, fifo_ovf = 0; a status read returns 8'h00.
- kbd_valid with 7'h61, FORCE_UPPER = 1 → key_ready rises 2 cycles later; data read returns 8'hC1; the next status read returns 8'h00.
- Stream "A\nB" (7'h41, 7'h0a, 7'h42) with PACE_CYCLES = 10 → reads return 8'hC1, 8'h8D, 8'hC2; the second acceptance occurs no earlier than 10 cycles after the first data read; strm_ready stays 0 in between.
- Typed key 7'h58 arrives while stream bytes are pending → 8'hD8 is delivered before the next stream byte; the stream resumes only after the FIFO is empty.
- Nine kbd_valid strobes with no CPU reads, FIFO_DEPTH = 8 → the first key is held; eight are queued without ovf; a tenth strobe sets fifo_ovf = 1; reads return the first nine keys in order.
- kbd_valid with 7'h1b while strm_active = 1 → strm_abort is high for exactly one cycle; the next data read returns 8'h9B; then assert rst mid-stream → all outputs return to reset values on the following cycle.

Source files
------------

// File: rtl/ascii_key_mux.sv
// Merges typed keys (FIFO-buffered, always first) and paced streamed bytes
// into the Apple-1 KBD / KBDCR register pair read through the PIA decode.
module ascii_key_mux #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] PACE_CYCLES = 16'd2500,
    parameter bit          FORCE_UPPER = 1'b1
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic [6:0] kbd_ascii,
    input  logic       kbd_valid,
    input  logic [6:0] strm_ascii,
    input  logic       strm_valid,
    output logic       strm_ready,
    input  logic       strm_active,
    output logic       strm_abort,
    input  logic       cs,
    input  logic       address,
    output logic [7:0] dout,
    output logic       key_ready,
    output logic       fifo_ovf
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // LF becomes CR for the monitor; lowercase optionally folded to uppercase.
    function automatic logic [6:0] map_char(input logic [6:0] c);
        logic [6:0] m;
        m = c;
        if (c == 7'h0a) begin
            m = 7'h0d;
        end else if (FORCE_UPPER && (c >= 7'h61) && (c <= 7'h7a)) begin
            m = c - 7'h20;
        end else begin
            m = c;
        end
        return m;
    endfunction

    logic [6:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [6:0]    hold_r;
    logic          key_ready_r;
    logic [7:0]    dout_r;
    logic          abort_r;
    logic          ovf_r;
    logic [15:0]   pace_r;

    logic [6:0]    kbd_char_s;
    logic [6:0]    strm_char_s;
    logic [6:0]    head_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          data_rd_s;
    logic          stat_rd_s;
    logic          pace_zero_s;
    logic          strm_ready_s;
    logic          take_s;
    logic          pop_s;
    logic          push_s;
    logic          ovf_set_s;
    logic          esc_s;
    logic          load_s;
    logic [6:0]    load_char_s;
    logic [CW-1:0] count_nxt_s;
    logic [15:0]   pace_nxt_s;
    logic [7:0]    dout_nxt_s;
    logic          key_ready_nxt_s;

    // Arbitration, FIFO control, CPU read data and pacing next-state.
    always_comb begin
        kbd_char_s      = map_char(kbd_ascii);
        strm_char_s     = map_char(strm_ascii);
        head_s          = mem_r[rd_ptr_r];
        fifo_empty_s    = (count_r == {CW{1'b0}});
        fifo_full_s     = (count_r == DEPTH_C);
        data_rd_s       = cs & ~address;
        stat_rd_s       = cs & address;
        pace_zero_s     = (pace_r == 16'd0);
        strm_ready_s    = ~key_ready_r & fifo_empty_s & pace_zero_s & strm_active & ~abort_r;
        take_s          = strm_ready_s & strm_valid;
        pop_s           = ~key_ready_r & ~fifo_empty_s;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_s          = kbd_valid & (~fifo_full_s | pop_s);
        ovf_set_s       = kbd_valid & fifo_full_s & ~pop_s;
        esc_s           = kbd_valid & (kbd_ascii == 7'h1b) & strm_active;
        load_s          = 1'b0;
        load_char_s     = hold_r;
        count_nxt_s     = count_r;
        pace_nxt_s      = pace_r;
        dout_nxt_s      = dout_r;
        key_ready_nxt_s = key_ready_r;

        if (pop_s) begin
            load_s      = 1'b1;
            load_char_s = head_s;
        end else if (take_s) begin
            load_s      = 1'b1;
            load_char_s = strm_char_s;
        end else begin
            load_s      = 1'b0;
            load_char_s = hold_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase

        if (data_rd_s) begin
            pace_nxt_s = PACE_CYCLES;
        end else if (!pace_zero_s) begin
            pace_nxt_s = pace_r - 16'd1;
        end else begin
            pace_nxt_s = pace_r;
        end

        if (data_rd_s) begin
            dout_nxt_s = {1'b1, hold_r};
        end else if (stat_rd_s) begin
            dout_nxt_s = {key_ready_r, 7'b000_0000};
        end else begin
            dout_nxt_s = dout_r;
        end

        // A load only happens with key_ready low, so it never races a clear.
        if (load_s) begin
            key_ready_nxt_s = 1'b1;
        end else if (data_rd_s) begin
            key_ready_nxt_s = 1'b0;
        end else begin
            key_ready_nxt_s = key_ready_r;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk25) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= kbd_char_s;
        end
    end

    // FIFO pointers and fill count.
    always_ff @(posedge clk25) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            count_r <= count_nxt_s;
        end
    end

    // Holding register, CPU-visible state, pacing and abort pulse.
    always_ff @(posedge clk25) begin
        if (rst) begin
            hold_r      <= 7'h00;
            key_ready_r <= 1'b0;
            dout_r      <= 8'h00;
            abort_r     <= 1'b0;
            ovf_r       <= 1'b0;
            pace_r      <= 16'd0;
        end else begin
            if (load_s) begin
                hold_r <= load_char_s;
            end
            key_ready_r <= key_ready_nxt_s;
            dout_r      <= dout_nxt_s;
            abort_r     <= esc_s;
            pace_r      <= pace_nxt_s;
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign strm_ready = strm_ready_s;
    assign strm_abort = abort_r;
    assign dout       = dout_r;
    assign key_ready  = key_ready_r;
    assign fifo_ovf   = ovf_r;

endmodule

// File: tb/tb_ascii_key_mux.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked
// cycle by cycle against a queue-based reference model of the key mux.
module tb_ascii_key_mux;

    localparam int          DEPTH = 8;
    localparam logic [15:0] PACE  = 16'd10;

    logic       clk25 = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] kbd_ascii = 7'h00;
    logic       kbd_valid = 1'b0;
    logic [6:0] strm_ascii = 7'h00;
    logic       strm_valid = 1'b0;
    logic       strm_ready;
    logic       strm_active = 1'b0;
    logic       strm_abort;
    logic       cs = 1'b0;
    logic       address = 1'b0;
    logic [7:0] dout;
    logic       key_ready;
    logic       fifo_ovf;

    ascii_key_mux #(.FIFO_DEPTH(DEPTH), .PACE_CYCLES(PACE), .FORCE_UPPER(1'b1)) dut (
        .clk25(clk25), .rst(rst), .kbd_ascii(kbd_ascii), .kbd_valid(kbd_valid),
        .strm_ascii(strm_ascii), .strm_valid(strm_valid), .strm_ready(strm_ready),
        .strm_active(strm_active), .strm_abort(strm_abort), .cs(cs), .address(address),
        .dout(dout), .key_ready(key_ready), .fifo_ovf(fifo_ovf)
    );

    always #5 clk25 = ~clk25;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_rd_cyc = 0;
    int last_acc_cyc = 0;

    // reference model state
    logic [6:0] m_q[$];
    logic [6:0] m_hold;
    bit         m_kr, m_abort, m_ovf;
    logic [7:0] m_dout;
    int         m_pace;

    // stream source
    logic [6:0] s_q[$];
    bit         s_on = 1'b0;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] ref_map(input logic [6:0] c);
        int v;
        v = int'(c);
        if (v == 10) v = 13;
        else if (v >= 97 && v <= 122) v = v - 32;
        return 7'(v);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_hold = 7'h00; m_kr = 1'b0; m_abort = 1'b0; m_ovf = 1'b0;
        m_dout = 8'h00; m_pace = 0;
    endtask

    // One clock cycle: inputs were set by the caller before this call.
    task automatic step();
        bit exp_rdy, acc, dr, sr, ld, kv, act, rs;
        logic [6:0] ka, sa;
        if (s_on && s_q.size() == 0) s_on = 1'b0;
        strm_active = s_on;
        strm_valid  = s_on && (s_q.size() > 0);
        strm_ascii  = (s_q.size() > 0) ? s_q[0] : 7'h00;
        #1;
        exp_rdy = !m_kr && (m_q.size() == 0) && (m_pace == 0) && s_on && !m_abort;
        check_eq("strm_ready", 8'(strm_ready), 8'(exp_rdy));
        acc = exp_rdy && strm_valid;
        dr = cs && !address; sr = cs && address;
        kv = kbd_valid; ka = kbd_ascii; sa = strm_ascii; act = strm_active; rs = rst;
        @(posedge clk25);
        cyc++;
        if (rs) begin
            model_reset();
        end else begin
            if (dr) m_dout = {1'b1, m_hold};
            else if (sr) m_dout = {m_kr, 7'h00};
            ld = 1'b0;
            if (!m_kr) begin
                if (m_q.size() > 0) begin
                    m_hold = m_q.pop_front(); ld = 1'b1;
                end else if (acc) begin
                    m_hold = ref_map(sa); ld = 1'b1;
                    void'(s_q.pop_front());
                    last_acc_cyc = cyc;
                end
            end
            if (ld) m_kr = 1'b1;
            else if (dr) m_kr = 1'b0;
            if (kv) begin
                if (m_q.size() < DEPTH) m_q.push_back(ref_map(ka));
                else m_ovf = 1'b1;
            end
            m_abort = kv && (ka == 7'h1b) && act;
            if (dr) begin
                m_pace = int'(PACE);
                last_rd_cyc = cyc;
            end else if (m_pace > 0) m_pace = m_pace - 1;
        end
        #1;
        check_eq("dout", dout, m_dout);
        check_eq("key_ready", 8'(key_ready), 8'(m_kr));
        check_eq("strm_abort", 8'(strm_abort), 8'(m_abort));
        check_eq("fifo_ovf", 8'(fifo_ovf), 8'(m_ovf));
        if (m_abort) begin
            s_q.delete(); s_on = 1'b0;
        end
        @(negedge clk25);
        kbd_valid = 1'b0; cs = 1'b0; address = 1'b0; rst = 1'b0;
    endtask

    task automatic kbd(input logic [6:0] c);
        kbd_valid = 1'b1; kbd_ascii = c; step();
    endtask

    task automatic rd_data(output logic [7:0] d);
        cs = 1'b1; address = 1'b0; step(); d = dout;
    endtask

    task automatic rd_stat(output logic [7:0] d);
        cs = 1'b1; address = 1'b1; step(); d = dout;
    endtask

    task automatic wait_kr(input int budget);
        int n = 0;
        while (!key_ready && n < budget) begin
            step(); n++;
        end
        check_eq("key_ready_wait", 8'(key_ready), 8'h01);
    endtask

    initial begin
        logic [7:0] d;
        model_reset();
        @(posedge clk25);
        @(negedge clk25);

        // reset state
        rst = 1'b1; step();
        check_eq("rst_dout", dout, 8'h00);
        check_eq("rst_kr", 8'(key_ready), 8'h00);
        rd_stat(d); check_eq("rst_status", d, 8'h00);

        // typed 'a' -> 'A', 2-cycle latency
        kbd(7'h61);
        check_eq("lat1_kr", 8'(key_ready), 8'h00);
        step();
        check_eq("lat2_kr", 8'(key_ready), 8'h01);
        rd_data(d); check_eq("rd_a", d, 8'hC1);
        rd_stat(d); check_eq("stat_after_rd", d, 8'h00);

        // stream "A\nB" with pacing
        s_q = '{7'h41, 7'h0a, 7'h42}; s_on = 1'b1;
        wait_kr(40); rd_data(d); check_eq("strm_A", d, 8'hC1);
        wait_kr(40);
        check_eq("pace_gap", 8'(last_acc_cyc - last_rd_cyc >= 10), 8'h01);
        rd_data(d); check_eq("strm_LF", d, 8'h8D);
        wait_kr(40); rd_data(d); check_eq("strm_B", d, 8'hC2);

        // typed key preempts pending stream bytes
        s_q = '{7'h31, 7'h32, 7'h33}; s_on = 1'b1;
        wait_kr(40);
        kbd(7'h58);
        rd_data(d); check_eq("prio_s1", d, 8'hB1);
        wait_kr(40); rd_data(d); check_eq("prio_X", d, 8'hD8);
        wait_kr(40); rd_data(d); check_eq("prio_s2", d, 8'hB2);
        wait_kr(40); rd_data(d); check_eq("prio_s3", d, 8'hB3);

        // FIFO fill and overflow
        for (int i = 0; i < 9; i++) kbd(7'(7'h30 + i));
        check_eq("nine_no_ovf", 8'(fifo_ovf), 8'h00);
        kbd(7'h39);
        check_eq("tenth_ovf", 8'(fifo_ovf), 8'h01);
        for (int i = 0; i < 9; i++) begin
            wait_kr(10); rd_data(d);
            check_eq("fifo_order", d, 8'(8'hB0 + i));
        end

        // ESC aborts the stream and is delivered as a key
        s_q = '{7'h41, 7'h42, 7'h43, 7'h44, 7'h45}; s_on = 1'b1;
        wait_kr(40); rd_data(d);
        kbd(7'h1b);
        check_eq("abort_hi", 8'(strm_abort), 8'h01);
        step();
        check_eq("abort_lo", 8'(strm_abort), 8'h00);
        wait_kr(40); rd_data(d); check_eq("rd_esc", d, 8'h9B);

        // reset mid-stream
        s_q = '{7'h61, 7'h62, 7'h63}; s_on = 1'b1;
        wait_kr(40); rd_data(d); step(); kbd(7'h55);
        rst = 1'b1; step();
        check_eq("mid_rst_dout", dout, 8'h00);
        check_eq("mid_rst_kr", 8'(key_ready), 8'h00);
        check_eq("mid_rst_ovf", 8'(fifo_ovf), 8'h00);
        s_q.delete(); s_on = 1'b0;
        step();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int r;
            if (!s_on && $urandom_range(0, 40) == 0) begin
                int len = $urandom_range(1, 6);
                for (int k = 0; k < len; k++) s_q.push_back(7'($urandom));
                s_on = 1'b1;
            end
            if (s_on && $urandom_range(0, 150) == 0) begin
                s_q.delete(); s_on = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 9);
                kbd_valid = 1'b1;
                if (r == 0) kbd_ascii = 7'h1b;
                else if (r == 1) kbd_ascii = 7'h0a;
                else if (r < 5) kbd_ascii = 7'(7'h61 + $urandom_range(0, 25));
                else kbd_ascii = 7'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                cs = 1'b1;
                address = (m_kr && $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            end
            if ($urandom_range(0, 600) == 0) rst = 1'b1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
